// File: rtl/senone_scorer_pkg.sv
`default_nettype none
// ============================================================================
// s_data_pkg : shared senone ROM record, scorer widths/states, saturation.
// Rev 1.0
// ============================================================================
package s_data_pkg;

    localparam int N_COMPONENTS = 6;
    localparam int ACC_W        = 56;
    localparam int TERM_W       = 50;

    typedef logic signed [15:0] num;

    typedef struct packed {
        num                    k;
        num [N_COMPONENTS-1:0] omegas;
        num [N_COMPONENTS-1:0] means;
    } senone_data;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FINAL = 2'd2,
        S_OUT   = 2'd3
    } scorer_state_t;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(32767);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-32768);

    function automatic num sat16(input logic signed [ACC_W:0] v);
        if (v > SAT_MAX)
            return 16'h7FFF;
        else if (v < SAT_MIN)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/senone_scorer_if.sv
`default_nettype none
// ============================================================================
// senone_scorer_if : score valid/ready channel toward the search logic.
// Rev 1.0
// ============================================================================
interface senone_scorer_if #(
    parameter int IDX_W = 5
);
    import s_data_pkg::*;

    num               score;
    logic [IDX_W-1:0] score_idx;
    logic             score_valid;
    logic             score_ready;

    modport master (output score, output score_idx, output score_valid, input score_ready);
    modport slave  (input score, input score_idx, input score_valid, output score_ready);

endinterface
`default_nettype wire

// File: rtl/senone_scorer_mac.sv
`default_nettype none
// ============================================================================
// scorer_mac : omega-weighted squared distance term for one feature component.
// Rev 1.0
// ============================================================================
module scorer_mac
    import s_data_pkg::*;
(
    input  num                       feat,
    input  num                       mean,
    input  num                       omega,
    output logic signed [TERM_W-1:0] term
);

    logic signed [16:0]       diff;
    logic signed [33:0]       diff_x;
    logic signed [33:0]       sq;
    logic signed [TERM_W-1:0] sq_x;
    logic signed [TERM_W-1:0] omega_x;

    assign diff    = {feat[15], feat} - {mean[15], mean};
    assign diff_x  = {{17{diff[16]}}, diff};
    assign sq      = diff_x * diff_x;
    // sq never exceeds 2^32, so zero-extension keeps it non-negative
    assign sq_x    = {16'b0, sq};
    assign omega_x = {{(TERM_W-16){omega[15]}}, omega};
    assign term    = sq_x * omega_x;

endmodule
`default_nettype wire

// File: rtl/senone_scorer.sv
`default_nettype none
// ============================================================================
// senone_scorer : walks all senones per frame, serial MAC scoring, valid/ready
// output. Optional SCORER_BEST_EN tracks the best score/index of the frame.
// Rev 1.0
// ============================================================================
module senone_scorer
    import s_data_pkg::*;
#(
    parameter int N_SENONES = 12,
    parameter int IDX_W     = 5,
    parameter int ACC_SHIFT = 8
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       start,
    input  logic [16*N_COMPONENTS-1:0] feature,
    output logic [IDX_W-1:0]           senone_index,
    input  senone_data                 senone,
    output logic                       busy,
    output logic                       done,
`ifdef SCORER_BEST_EN
    output num                         best_score,
    output logic [IDX_W-1:0]           best_idx,
`endif
    senone_scorer_if.master            score_if
);

    localparam int                COMP_W    = (N_COMPONENTS > 1) ? $clog2(N_COMPONENTS) : 1;
    localparam logic [COMP_W-1:0] LAST_COMP = COMP_W'(N_COMPONENTS-1);
    localparam logic [IDX_W-1:0]  LAST_SEN  = IDX_W'(N_SENONES-1);

    scorer_state_t             state, state_n;
    logic [IDX_W-1:0]          sen_cnt;
    logic [COMP_W-1:0]         comp;
    logic signed [ACC_W-1:0]   acc;
    num [N_COMPONENTS-1:0]     feat_q;
    num                        score_q;
    logic [IDX_W-1:0]          score_idx_q;

    logic signed [TERM_W-1:0]  term;
    logic signed [ACC_W-1:0]   acc_shr;
    logic signed [ACC_W:0]     final_s;
    num                        sat_s;
    logic                      handshake;
    logic                      last_sen;

    scorer_mac u_mac (
        .feat  (feat_q[comp]),
        .mean  (senone.means[comp]),
        .omega (senone.omegas[comp]),
        .term  (term)
    );

    assign acc_shr  = acc >>> ACC_SHIFT;
    assign final_s  = {{(ACC_W+1-16){senone.k[15]}}, senone.k} - {acc_shr[ACC_W-1], acc_shr};
    assign sat_s    = sat16(final_s);
    assign last_sen = (sen_cnt == LAST_SEN);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        handshake = 1'b0;
        case (state)
            S_IDLE:  if (start) state_n = S_ACCUM;
            S_ACCUM: if (comp == LAST_COMP) state_n = S_FINAL;
            S_FINAL: state_n = S_OUT;
            S_OUT: begin
                if (score_if.score_ready) begin
                    handshake = 1'b1;
                    state_n   = last_sen ? S_IDLE : S_ACCUM;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy                 = (state != S_IDLE);
    assign done                 = handshake && last_sen;
    assign senone_index         = busy ? sen_cnt : '0;
    assign score_if.score       = score_q;
    assign score_if.score_idx   = score_idx_q;
    assign score_if.score_valid = (state == S_OUT);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            feat_q      <= '0;
            sen_cnt     <= '0;
            comp        <= '0;
            acc         <= '0;
            score_q     <= '0;
            score_idx_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        feat_q  <= feature;
                        sen_cnt <= '0;
                        comp    <= '0;
                        acc     <= '0;
                    end
                end
                S_ACCUM: begin
                    acc  <= acc + {{(ACC_W-TERM_W){term[TERM_W-1]}}, term};
                    comp <= (comp == LAST_COMP) ? '0 : comp + 1'b1;
                end
                S_FINAL: begin
                    score_q     <= sat_s;
                    score_idx_q <= sen_cnt;
                end
                S_OUT: begin
                    if (handshake && !last_sen) begin
                        sen_cnt <= sen_cnt + 1'b1;
                        comp    <= '0;
                        acc     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCORER_BEST_EN
    // Folded in as each score is registered, so the done cycle already
    // reflects the last senone; the strict compare keeps the lower index on ties.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            best_score <= '0;
            best_idx   <= '0;
        end else if (state == S_IDLE && start) begin
            best_score <= 16'h8000;
            best_idx   <= '0;
        end else if (state == S_FINAL && sat_s > best_score) begin
            best_score <= sat_s;
            best_idx   <= sen_cnt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_senone_scorer.sv
`default_nettype none
// ============================================================================
// tb_senone_scorer : table-driven frames with a model scoreboard, plus
// backpressure, ignored-start and reset-abort sequences.
// Rev 1.0
// ============================================================================
module tb_senone_scorer;
    import s_data_pkg::*;

    localparam int NS        = 12;
    localparam int IW        = 5;
    localparam int ROM_DEPTH = 10;
    localparam int FW        = 16*N_COMPONENTS;

    localparam int SEL_REAL = 0;
    localparam int SEL_ONE  = 1;
    localparam int SEL_SATN = 2;
    localparam int SEL_SATP = 3;
    localparam int SEL_TIE  = 4;

    typedef struct { int idx; num score; } exp_t;
    typedef struct {
        logic [FW-1:0] feature;
        int            sel;
        bit            chk0;
        logic [15:0]   exp0;
        int            exp_best;
    } vec_t;

    logic          clk     = 1'b0;
    logic          n_reset = 1'b0;
    logic          start   = 1'b0;
    logic [FW-1:0] feature = '0;
    logic [IW-1:0] senone_index;
    senone_data    senone;
    logic          busy;
    logic          done;
    int            rom_sel = SEL_REAL;
`ifdef SCORER_BEST_EN
    num            best_score;
    logic [IW-1:0] best_idx;
    num            exp_best_score;
    int            exp_best_idx;
`endif

    senone_scorer_if #(.IDX_W(IW)) sif ();

    senone_scorer #(.N_SENONES(NS), .IDX_W(IW), .ACC_SHIFT(8)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .start        (start),
        .feature      (feature),
        .senone_index (senone_index),
        .senone       (senone),
        .busy         (busy),
        .done         (done),
`ifdef SCORER_BEST_EN
        .best_score   (best_score),
        .best_idx     (best_idx),
`endif
        .score_if     (sif)
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] idx0_score;
    vec_t        vecs[6];

    function automatic senone_data rom_entry(input int sel, input int idx);
        senone_data  d;
        logic [15:0] m0 [N_COMPONENTS] = '{16'hEBCB, 16'hFA2D, 16'hFADD, 16'hF9E4, 16'h0EF7, 16'h17A3};
        d = '0;
        if (idx >= ROM_DEPTH) return d;
        for (int c = 0; c < N_COMPONENTS; c++) begin
            case (sel)
                SEL_REAL: begin
                    d.omegas[c] = 16'(2 + c);
                    d.means[c]  = (idx == 0) ? m0[c] : 16'(idx*'h731 + c*'h1111);
                end
                SEL_ONE:  d.omegas[c] = 16'h0001;
                SEL_SATN: begin d.omegas[c] = 16'h0030; d.means[c] = 16'h8000; end
                SEL_SATP: d.omegas[c] = 16'hFFFF;
                default:  ;
            endcase
        end
        case (sel)
            SEL_REAL: d.k = (idx == 0) ? 16'hD075 : (idx == 6) ? 16'h7000 : 16'(16'h1000 + idx*256);
            SEL_SATP: d.k = 16'h7FFF;
            SEL_TIE:  d.k = (idx == 2 || idx == 7) ? 16'h0100 : 16'h0000;
            default:  d.k = 16'h0000;
        endcase
        return d;
    endfunction

    assign senone = rom_entry(rom_sel, int'(senone_index));

    function automatic num model_score(input logic [FW-1:0] f, input senone_data d);
        longint          acc = 0;
        longint          diff;
        longint          s;
        logic signed [15:0] fe;
        for (int c = 0; c < N_COMPONENTS; c++) begin
            fe   = f[16*c +: 16];
            diff = longint'(fe) - longint'(d.means[c]);
            acc += diff * diff * longint'(d.omegas[c]);
        end
        s = longint'(d.k) - (acc >>> 8);
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [FW-1:0] f);
        exp_t e;
`ifdef SCORER_BEST_EN
        exp_best_score = 16'h8000;
        exp_best_idx   = 0;
`endif
        for (int i = 0; i < NS; i++) begin
            e.idx   = i;
            e.score = model_score(f, rom_entry(rom_sel, i));
            sb_q.push_back(e);
`ifdef SCORER_BEST_EN
            if (e.score > exp_best_score) begin
                exp_best_score = e.score;
                exp_best_idx   = i;
            end
`endif
        end
    endtask

    task automatic launch(input logic [FW-1:0] f);
        @(posedge clk); #1;
        feature = f;
        start   = 1'b1;
        push_frame(f);
        @(posedge clk); #1;
        start   = 1'b0;
        feature = ~f;
    endtask

    // t counts edges after the accepting edge; the frame spans 96 cycles
    // including the start cycle, so done shows at t = 95 and first valid at 7.
    task automatic run_frame(input logic [FW-1:0] f, output int t_valid, output int t_done);
        t_valid = -1;
        t_done  = -1;
        launch(f);
        for (int t = 0; t < 200; t++) begin
            if (sif.score_valid && t_valid < 0) t_valid = t;
            if (done) begin
                t_done = t;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_accum(input int idx);
        bit ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (busy && senone_index == IW'(idx) && !sif.score_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("wait_accum_reached", 32'(ok), 1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("done_seen", 32'(ok), 1);
    endtask

    always @(negedge clk) begin
        if (n_reset && sif.score_valid && sif.score_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_score", 32'(sif.score_idx), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                check("score_idx", 32'(sif.score_idx), 32'(mon_e.idx));
                check("score", {16'b0, sif.score}, {16'b0, mon_e.score});
                if (sif.score_idx == '0) idx0_score = sif.score;
            end
        end
    end

    initial begin
        int          tv, td;
        logic [FW-1:0] fa, fb, fc;
        num          held;

        sif.score_ready = 1'b1;
        fa = {16'h0123, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h1000, 16'hE000};
        fb = {16'h0400, 16'h0300, 16'h0200, 16'h0100, 16'h0050, 16'h0010};
        fc = {N_COMPONENTS{16'h5A5A}};

        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(sif.score_valid), 0);
        check("rst_score", {16'b0, sif.score}, 0);
        check("rst_score_idx", 32'(sif.score_idx), 0);
        check("rst_senone_index", 32'(senone_index), 0);
        check("rst_done", 32'(done), 0);
        @(posedge clk); #1;
        n_reset = 1'b1;

        vecs[0] = '{rom_entry(SEL_REAL, 0).means, SEL_REAL, 1'b1, 16'hD075, -1};
        vecs[1] = '{FW'(16'h0010), SEL_ONE, 1'b1, 16'hFFFF, -1};
        vecs[2] = '{{N_COMPONENTS{16'h7FFF}}, SEL_SATN, 1'b1, 16'h8000, -1};
        vecs[3] = '{{N_COMPONENTS{16'h7FFF}}, SEL_SATP, 1'b1, 16'h7FFF, -1};
        vecs[4] = '{rom_entry(SEL_REAL, 6).means, SEL_REAL, 1'b0, 16'h0000, 6};
        vecs[5] = '{'0, SEL_TIE, 1'b1, 16'h0000, 2};

        for (int r = 0; r < 6; r++) begin
            rom_sel    = vecs[r].sel;
            idx0_score = 'x;
            run_frame(vecs[r].feature, tv, td);
            check("first_valid_latency", 32'(tv), 7);
            check("done_latency", 32'(td), 95);
`ifdef SCORER_BEST_EN
            check("best_idx_model", 32'(best_idx), 32'(exp_best_idx));
            check("best_score_model", {16'b0, best_score}, {16'b0, exp_best_score});
            if (vecs[r].exp_best >= 0) check("best_idx_const", 32'(best_idx), 32'(vecs[r].exp_best));
`endif
            @(negedge clk); #1;
            check("sb_drained", 32'(sb_q.size()), 0);
            if (vecs[r].chk0) check("score_idx0_const", {16'b0, idx0_score}, {16'b0, vecs[r].exp0});
        end

        // backpressure on senone 3
        rom_sel = SEL_REAL;
        launch(fb);
        wait_accum(3);
        sif.score_ready = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (sif.score_valid) break;
            @(posedge clk); #1;
        end
        held = sif.score;
        for (int j = 0; j < 5; j++) begin
            check("bp_valid", 32'(sif.score_valid), 1);
            check("bp_score_idx", 32'(sif.score_idx), 3);
            check("bp_senone_index", 32'(senone_index), 3);
            check("bp_score_stable", {16'b0, sif.score}, {16'b0, held});
            @(posedge clk); #1;
        end
        sif.score_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_next_index", 32'(senone_index), 4);
        check("bp_next_valid", 32'(sif.score_valid), 0);
        check("bp_next_busy", 32'(busy), 1);
        wait_done();
        @(negedge clk); #1;
        check("bp_sb_drained", 32'(sb_q.size()), 0);

        // ignored start, then abort by reset
        launch(fa);
        wait_accum(2);
        feature = fc;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        check("restart_ignored_busy", 32'(busy), 1);
        check("restart_ignored_index", 32'(senone_index), 2);
        wait_accum(5);
        #2;
        n_reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(sif.score_valid), 0);
        check("abort_score", {16'b0, sif.score}, 0);
        check("abort_senone_index", 32'(senone_index), 0);
        check("abort_done", 32'(done), 0);
        sb_q.delete();
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            check("abort_hold_done", 32'(done), 0);
            check("abort_hold_busy", 32'(busy), 0);
        end
        n_reset = 1'b1;
        run_frame(fa, tv, td);
        check("rerun_first_valid", 32'(tv), 7);
        check("rerun_done", 32'(td), 95);
        @(negedge clk); #1;
        check("rerun_sb_drained", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
